// File: rtl/window_5x5_gen.sv
// Raster-scan 5x5 window generator feeding a 25-input sorter.
// Define WINDOW_5X5_LAST_EN to add the win_last frame-end flag.
module window_5x5_gen #(
  parameter int DSIZE  = 64,
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_sof,
  input  logic [DSIZE-1:0] in_data,
  output logic             out_valid,
`ifdef WINDOW_5X5_LAST_EN
  output logic             win_last,
`endif
  output logic [DSIZE-1:0] wd00, wd01, wd02, wd03, wd04,
  output logic [DSIZE-1:0] wd05, wd06, wd07, wd08, wd09,
  output logic [DSIZE-1:0] wd10, wd11, wd12, wd13, wd14,
  output logic [DSIZE-1:0] wd15, wd16, wd17, wd18, wd19,
  output logic [DSIZE-1:0] wd20, wd21, wd22, wd23, wd24
);

  localparam int CW = $clog2(WIDTH);
  localparam int RW = $clog2(HEIGHT);

  logic [CW-1:0]    col, cur_col, nxt_col;
  logic [RW-1:0]    row, cur_row, nxt_row;
  logic             eol, eof, win_hit;
  logic [DSIZE-1:0] lb   [4][WIDTH];
  logic [DSIZE-1:0] tap  [5][5];
  logic [DSIZE-1:0] head [5];

  // in_sof forces the current sample to (0,0) regardless of counters
  always_comb begin
    cur_col = in_sof ? '0 : col;
    cur_row = in_sof ? '0 : row;
    eol     = (cur_col == CW'(WIDTH - 1));
    eof     = (cur_row == RW'(HEIGHT - 1));
    nxt_col = eol ? '0 : cur_col + 1'b1;
    nxt_row = cur_row;
    if (eol) nxt_row = eof ? '0 : cur_row + 1'b1;
    win_hit = (cur_row >= RW'(4)) && (cur_col >= CW'(4));
    head[4] = in_data;
    for (int k = 0; k < 4; k++) head[3-k] = lb[k][cur_col];
  end

  // lb[0] holds line row-1, lb[3] holds line row-4
  always_ff @(posedge clock) begin
    if (in_valid) begin
      lb[0][cur_col] <= in_data;
      for (int k = 1; k < 4; k++) lb[k][cur_col] <= lb[k-1][cur_col];
    end
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      col       <= '0;
      row       <= '0;
      out_valid <= 1'b0;
`ifdef WINDOW_5X5_LAST_EN
      win_last  <= 1'b0;
`endif
      for (int r = 0; r < 5; r++)
        for (int c = 0; c < 5; c++) tap[r][c] <= '0;
    end else begin
      out_valid <= in_valid && win_hit;
`ifdef WINDOW_5X5_LAST_EN
      win_last  <= in_valid && win_hit && eol && eof;
`endif
      if (in_valid) begin
        col <= nxt_col;
        row <= nxt_row;
        for (int r = 0; r < 5; r++) begin
          for (int c = 0; c < 4; c++) tap[r][c] <= tap[r][c+1];
          tap[r][4] <= head[r];
        end
      end
    end
  end

  assign wd00 = tap[0][0]; assign wd01 = tap[0][1];
  assign wd02 = tap[0][2]; assign wd03 = tap[0][3];
  assign wd04 = tap[0][4]; assign wd05 = tap[1][0];
  assign wd06 = tap[1][1]; assign wd07 = tap[1][2];
  assign wd08 = tap[1][3]; assign wd09 = tap[1][4];
  assign wd10 = tap[2][0]; assign wd11 = tap[2][1];
  assign wd12 = tap[2][2]; assign wd13 = tap[2][3];
  assign wd14 = tap[2][4]; assign wd15 = tap[3][0];
  assign wd16 = tap[3][1]; assign wd17 = tap[3][2];
  assign wd18 = tap[3][3]; assign wd19 = tap[3][4];
  assign wd20 = tap[4][0]; assign wd21 = tap[4][1];
  assign wd22 = tap[4][2]; assign wd23 = tap[4][3];
  assign wd24 = tap[4][4];

endmodule

// File: tb/tb_window_5x5_gen.sv
// Self-checking bench for window_5x5_gen on an 8x6 frame of 8-bit samples.
// Compile with WINDOW_5X5_LAST_EN defined to also check win_last.
module tb_window_5x5_gen;

  localparam int W = 8;
  localparam int H = 6;

  logic       clock = 1'b0;
  logic       rst, in_valid, in_sof;
  logic [7:0] in_data;
  logic       out_valid;
`ifdef WINDOW_5X5_LAST_EN
  logic       win_last;
`endif
  logic [7:0] wd00, wd01, wd02, wd03, wd04, wd05, wd06, wd07, wd08, wd09;
  logic [7:0] wd10, wd11, wd12, wd13, wd14, wd15, wd16, wd17, wd18, wd19;
  logic [7:0] wd20, wd21, wd22, wd23, wd24;
  logic [199:0] dw;

  always #5 clock = ~clock;

  window_5x5_gen #(.DSIZE(8), .WIDTH(W), .HEIGHT(H)) dut (
    .clock(clock), .rst(rst), .in_valid(in_valid), .in_sof(in_sof),
    .in_data(in_data), .out_valid(out_valid),
`ifdef WINDOW_5X5_LAST_EN
    .win_last(win_last),
`endif
    .wd00(wd00), .wd01(wd01), .wd02(wd02), .wd03(wd03), .wd04(wd04),
    .wd05(wd05), .wd06(wd06), .wd07(wd07), .wd08(wd08), .wd09(wd09),
    .wd10(wd10), .wd11(wd11), .wd12(wd12), .wd13(wd13), .wd14(wd14),
    .wd15(wd15), .wd16(wd16), .wd17(wd17), .wd18(wd18), .wd19(wd19),
    .wd20(wd20), .wd21(wd21), .wd22(wd22), .wd23(wd23), .wd24(wd24)
  );

  assign dw = {wd24, wd23, wd22, wd21, wd20, wd19, wd18, wd17, wd16,
               wd15, wd14, wd13, wd12, wd11, wd10, wd09, wd08, wd07,
               wd06, wd05, wd04, wd03, wd02, wd01, wd00};

  typedef struct {
    logic [199:0] w;
    logic         l;
  } cap_t;

  typedef struct {
    logic [7:0] p00, p04, p20, p24;
    logic       last;
  } vec_t;

  cap_t       got [$];
  vec_t       tbl [8];
  int         checks, failures;
  int         mrow, mcol;
  logic [7:0] img [H][W];

  task automatic chk(string n, logic [199:0] a, logic [199:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", n, a, e);
    end
  endtask

  // One clock: drive, then compare against the image model after the edge
  task automatic cyc(bit v, bit s, logic [7:0] d);
    logic [199:0] prev, ew;
    bit ev, el;
    cap_t cp;
    prev = dw;
    in_valid = v; in_sof = s; in_data = d;
    @(posedge clock); #1;
    ev = 0; el = 0; ew = '0;
    if (v) begin
      if (s) begin mrow = 0; mcol = 0; end
      img[mrow][mcol] = d;
      ev = (mrow >= 4) && (mcol >= 4);
      el = (mrow == H - 1) && (mcol == W - 1);
      if (ev)
        for (int k = 0; k < 25; k++)
          ew[k*8 +: 8] = img[mrow - 4 + k / 5][mcol - 4 + k % 5];
      mcol++;
      if (mcol == W) begin
        mcol = 0; mrow++;
        if (mrow == H) mrow = 0;
      end
    end
    chk("out_valid", out_valid, ev);
    cp.w = dw; cp.l = 0;
`ifdef WINDOW_5X5_LAST_EN
    chk("win_last", win_last, el && ev);
    cp.l = win_last;
`endif
    if (ev) begin
      chk("window", dw, ew);
      got.push_back(cp);
    end
    if (!v) chk("hold", dw, prev);
    in_valid = 0; in_sof = 0;
  endtask

  task automatic pix(int r, int c, bit s, int gap);
    while ($urandom_range(99) < gap) cyc(0, 0, 8'($urandom));
    cyc(1, s, 8'(r * 16 + c));
  endtask

  task automatic frame(bit sof, int gap);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) pix(r, c, sof && r == 0 && c == 0, gap);
  endtask

  task automatic cmp_tbl(int base);
    for (int i = 0; i < 8; i++) begin
      if (base + i < got.size()) begin
        chk("tbl_wd00", got[base+i].w[7:0],     tbl[i].p00);
        chk("tbl_wd04", got[base+i].w[39:32],   tbl[i].p04);
        chk("tbl_wd20", got[base+i].w[167:160], tbl[i].p20);
        chk("tbl_wd24", got[base+i].w[199:192], tbl[i].p24);
`ifdef WINDOW_5X5_LAST_EN
        chk("tbl_last", got[base+i].l, tbl[i].last);
`endif
      end else begin
        chk("tbl_missing", got.size(), base + i + 1);
      end
    end
  endtask

  task automatic rst_zero(string n);
    chk({n, "_valid"}, out_valid, 0);
    chk({n, "_win"}, dw, 0);
`ifdef WINDOW_5X5_LAST_EN
    chk({n, "_last"}, win_last, 0);
`endif
  endtask

  initial begin
    tbl[0] = '{8'h00, 8'h04, 8'h40, 8'h44, 1'b0};
    tbl[1] = '{8'h01, 8'h05, 8'h41, 8'h45, 1'b0};
    tbl[2] = '{8'h02, 8'h06, 8'h42, 8'h46, 1'b0};
    tbl[3] = '{8'h03, 8'h07, 8'h43, 8'h47, 1'b0};
    tbl[4] = '{8'h10, 8'h14, 8'h50, 8'h54, 1'b0};
    tbl[5] = '{8'h11, 8'h15, 8'h51, 8'h55, 1'b0};
    tbl[6] = '{8'h12, 8'h16, 8'h52, 8'h56, 1'b0};
    tbl[7] = '{8'h13, 8'h17, 8'h53, 8'h57, 1'b1};
    checks = 0; failures = 0;
    mrow = 0; mcol = 0;
    rst = 1; in_valid = 0; in_sof = 0; in_data = 0;
    #12;
    rst_zero("reset");
    rst = 0;

    // continuous frame
    got.delete();
    frame(1, 0);
    chk("cont_count", got.size(), 8);
    cmp_tbl(0);

    // 50% input gaps
    got.delete();
    frame(1, 50);
    chk("gap_count", got.size(), 8);
    cmp_tbl(0);

    // in_sof restarts the frame at sample 0x23
    got.delete();
    for (int i = 0; i < 8'h23; i++)
      if (i % 16 < W) pix(i / 16, i % 16, i == 0, 0);
    frame(1, 0);
    chk("sof_count", got.size(), 8);
    cmp_tbl(0);

    // reset pulse after sample 0x45, then a frame without in_sof
    got.delete();
    for (int i = 0; i <= 8'h45; i++)
      if (i % 16 < W) pix(i / 16, i % 16, i == 0, 0);
    chk("pre_rst_count", got.size(), 2);
    rst = 1;
    #1;
    rst_zero("pulse");
    @(posedge clock); #1;
    rst_zero("pulse_hold");
    rst = 0;
    mrow = 0; mcol = 0;
    got.delete();
    frame(0, 0);
    chk("post_rst_count", got.size(), 8);
    cmp_tbl(0);

    // two frames back to back with no in_sof
    got.delete();
    frame(0, 0);
    frame(0, 0);
    chk("b2b_count", got.size(), 16);
    cmp_tbl(0);
    cmp_tbl(8);

    // random data, gaps and occasional in_sof against the model
    for (int i = 0; i < 800; i++) begin
      bit v, s;
      v = 1'($urandom_range(1));
      s = v && ($urandom_range(59) == 0);
      cyc(v, s, 8'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
